alarm_ring_controller: RTL and testbench
========================================

Name: alarm_ring_controller

Overview:
Sequences the alarm resource of the digital clock. Compares running time against the stored alarm time and drives alarm_sound. Manages ring timeout, snooze with wrap-around re-scheduling, and dismiss. Sits beside the mode FSM, fed by the normal timekeeper, the alarm-set datapath and the debounced user buttons.

Parameters:
RING_TIMEOUT_S, 60, seconds of continuous ringing before auto-dismiss (legal 1..63)
SNOOZE_MIN, 5, minutes added per snooze (legal 1..59)
MAX_SNOOZES, 3, snoozes allowed per alarm event (legal 0..3)

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-low
tick_1hz  input  1  one-cycle pulse per second
normal_hours  input  5  current hours, 0..23
normal_minutes  input  6  current minutes, 0..59
alarm_hours  input  5  stored alarm hours, binary 0..23
alarm_minutes  input  6  stored alarm minutes, binary 0..59
on_off_alarm  input  1  alarm enabled
set_alarm_en  input  1  alarm edit mode active
snooze_button  input  1  debounced level
stop_button  input  1  debounced level
alarm_sound  output  1  buzzer drive, registered
snooze_active  output  1  high in SNOOZED, registered
snooze_count  output  2  snoozes used in the current event
snooze_hours  output  5  scheduled re-ring hour
snooze_minutes  output  6  scheduled re-ring minute

Behaviour:
- Reset (rst=0 at posedge clk): state=IDLE, alarm_sound=0, snooze_active=0, snooze_count=0, snooze_hours/minutes=0, ring_sec=0, armed=0, button history regs=0. Reset mid-ring silences on that edge.
- Buttons: rising-edge detected internally (prev-sample reg). A held button produces one event.
- match = (normal_hours==alarm_hours) & (normal_minutes==alarm_minutes).
- armed: set when match=0; cleared on entry to RINGING. At most one trigger per matching minute. No ring in the minute of reset.
- Abort (highest priority, any state): on_off_alarm=0 or set_alarm_en=1 -> IDLE, snooze_count=0.
- IDLE: on match & armed & on_off_alarm & !set_alarm_en -> RINGING next edge, ring_sec=0. alarm_sound rises on that same edge (1-cycle latency from match).
- RINGING: alarm_sound=1. ring_sec increments on tick_1hz.
  - stop edge -> IDLE, snooze_count=0.
  - snooze edge with snooze_count<MAX_SNOOZES -> SNOOZED. snooze_count+1. snooze_hours/minutes latched = current time + SNOOZE_MIN.
  - snooze edge at the limit is ignored; ringing continues.
  - tick_1hz with ring_sec==RING_TIMEOUT_S-1 -> IDLE, snooze_count=0.
  - Priority: stop > snooze > timeout.
- SNOOZED: alarm_sound=0, snooze_active=1.
  - stop edge -> IDLE, count cleared.
  - (normal time == snooze_hours/minutes) -> RINGING, ring_sec=0.
  - snooze edge ignored.
- Time add: min_sum = minutes + SNOOZE_MIN, 7-bit.
  - If min_sum>=60: minutes = min_sum-60 and hours+1; else minutes = min_sum.
  - Hours 24 wraps to 0.
- Unused state encoding -> IDLE.
- snooze_count holds its value through IDLE until the next trigger clears it. Clear on trigger as well as on dismiss.

Decomposition:
- Shared package clock_pkg holds:
  - state enum {IDLE, RINGING, SNOOZED}
  - HOURS_W=5, MIN_W=6
  - HOURS_PER_DAY=24, MIN_PER_HOUR=60
- Sub-module time_add_minutes: combinational hours/minutes + constant with minute and day wrap. It is reusable by the set-time datapath.
- Everything else stays in one module.

Test Plan:
- Alarm 07:30, enabled, time steps 07:29->07:30 -> alarm_sound=1 one clk after minutes becomes 30; stop at 07:30:10 -> alarm_sound=0, no re-ring for the rest of 07:30.
- Ring at 23:58, snooze -> snooze_active=1, snooze 00:03, count=1; time reaches 00:03 -> alarm_sound=1, snooze_active=0.
- Three snoozes from 06:00 (re-rings at 06:05, 06:10, 06:15); fourth snooze at 06:15 -> ignored, alarm_sound stays 1, count=3.
- Ring, no buttons, 60 tick_1hz pulses -> alarm_sound falls on the edge of the 60th tick; count=0.
- While RINGING, stop and snooze asserted the same cycle -> IDLE, count=0. While SNOOZED, drop on_off_alarm -> IDLE, no re-ring at snooze time.
- While RINGING, assert rst=0 for one clk -> all outputs 0. Release rst during the same matching minute -> no ring until match deasserts and recurs.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and time constants for the digital clock blocks.
// Imported by the alarm ring controller and the time-add helper.
package clock_pkg;

  localparam int HOURS_W       = 5;
  localparam int MIN_W         = 6;
  localparam int HOURS_PER_DAY = 24;
  localparam int MIN_PER_HOUR  = 60;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_e;

endpackage

// File: rtl/alarm_ring_controller_time_add.sv
// Combinational hh:mm + ADD_MIN minutes, with wrap at the hour and at midnight.
// Kept free of alarm specifics so the set-time datapath can reuse it.
module time_add_minutes
  import clock_pkg::*;
#(
  parameter int ADD_MIN = 5
) (
  input  logic [HOURS_W-1:0] hours_i,
  input  logic [MIN_W-1:0]   minutes_i,
  output logic [HOURS_W-1:0] hours_o,
  output logic [MIN_W-1:0]   minutes_o
);

  logic [6:0]         min_sum;
  logic [6:0]         min_wrapped;
  logic [HOURS_W-1:0] hours_inc;

  always_comb begin
    min_sum     = {1'b0, minutes_i} + 7'(ADD_MIN);
    min_wrapped = min_sum - 7'(MIN_PER_HOUR);
    hours_inc   = hours_i + 5'd1;
    hours_o     = hours_i;
    minutes_o   = min_sum[MIN_W-1:0];
    if (min_sum >= 7'(MIN_PER_HOUR)) begin
      minutes_o = min_wrapped[MIN_W-1:0];
      // 23 + 1 lands on 24, which is midnight of the next day
      hours_o   = (hours_inc == 5'(HOURS_PER_DAY)) ? '0 : hours_inc;
    end
  end

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm sequencing: match detect, ring timeout, snooze re-scheduling and dismiss.
// Outputs are registered copies of the next state so the buzzer moves on the decision edge.
module alarm_ring_controller
  import clock_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_MIN     = 5,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic [HOURS_W-1:0] normal_hours,
  input  logic [MIN_W-1:0]   normal_minutes,
  input  logic [HOURS_W-1:0] alarm_hours,
  input  logic [MIN_W-1:0]   alarm_minutes,
  input  logic               on_off_alarm,
  input  logic               set_alarm_en,
  input  logic               snooze_button,
  input  logic               stop_button,
  output logic               alarm_sound,
  output logic               snooze_active,
  output logic [1:0]         snooze_count,
  output logic [HOURS_W-1:0] snooze_hours,
  output logic [MIN_W-1:0]   snooze_minutes
);

  localparam logic [5:0] RING_LAST = 6'(RING_TIMEOUT_S - 1);
  localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZES);

  state_e             state_q, state_d;
  logic               alarm_sound_q, alarm_sound_d;
  logic               snooze_active_q, snooze_active_d;
  logic [1:0]         snooze_count_q, snooze_count_d;
  logic [HOURS_W-1:0] snooze_hours_q, snooze_hours_d;
  logic [MIN_W-1:0]   snooze_minutes_q, snooze_minutes_d;
  logic [5:0]         ring_sec_q, ring_sec_d;
  logic               armed_q, armed_d;
  logic               snooze_prev_q, stop_prev_q;

  logic               match, snooze_match, abort, enter_ring;
  logic               snooze_edge, stop_edge;
  logic [HOURS_W-1:0] resched_hours;
  logic [MIN_W-1:0]   resched_minutes;

  time_add_minutes #(.ADD_MIN(SNOOZE_MIN)) u_snooze_add (
    .hours_i   (normal_hours),
    .minutes_i (normal_minutes),
    .hours_o   (resched_hours),
    .minutes_o (resched_minutes)
  );

  always_comb begin
    match        = (normal_hours == alarm_hours) && (normal_minutes == alarm_minutes);
    snooze_match = (normal_hours == snooze_hours_q) && (normal_minutes == snooze_minutes_q);
    snooze_edge  = snooze_button && !snooze_prev_q;
    stop_edge    = stop_button && !stop_prev_q;
    abort        = !on_off_alarm || set_alarm_en;

    state_d          = state_q;
    snooze_count_d   = snooze_count_q;
    snooze_hours_d   = snooze_hours_q;
    snooze_minutes_d = snooze_minutes_q;
    ring_sec_d       = ring_sec_q;
    enter_ring       = 1'b0;

    if (abort) begin
      state_d        = IDLE;
      snooze_count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (match && armed_q) begin
            state_d        = RINGING;
            ring_sec_d     = '0;
            snooze_count_d = '0;
            enter_ring     = 1'b1;
          end
        end
        RINGING: begin
          if (stop_edge) begin
            state_d        = IDLE;
            snooze_count_d = '0;
          end else if (snooze_edge && (snooze_count_q < SNZ_MAX)) begin
            state_d          = SNOOZED;
            snooze_count_d   = snooze_count_q + 2'd1;
            snooze_hours_d   = resched_hours;
            snooze_minutes_d = resched_minutes;
          end else if (tick_1hz) begin
            if (ring_sec_q == RING_LAST) begin
              state_d        = IDLE;
              snooze_count_d = '0;
            end else begin
              ring_sec_d = ring_sec_q + 6'd1;
            end
          end
        end
        SNOOZED: begin
          if (stop_edge) begin
            state_d        = IDLE;
            snooze_count_d = '0;
          end else if (snooze_match) begin
            state_d    = RINGING;
            ring_sec_d = '0;
            enter_ring = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Re-arm only once the alarm minute has passed: one trigger per matching minute
    armed_d         = enter_ring ? 1'b0 : (armed_q || !match);
    alarm_sound_d   = (state_d == RINGING);
    snooze_active_d = (state_d == SNOOZED);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= IDLE;
      alarm_sound_q    <= 1'b0;
      snooze_active_q  <= 1'b0;
      snooze_count_q   <= '0;
      snooze_hours_q   <= '0;
      snooze_minutes_q <= '0;
      ring_sec_q       <= '0;
      armed_q          <= 1'b0;
      snooze_prev_q    <= 1'b0;
      stop_prev_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      alarm_sound_q    <= alarm_sound_d;
      snooze_active_q  <= snooze_active_d;
      snooze_count_q   <= snooze_count_d;
      snooze_hours_q   <= snooze_hours_d;
      snooze_minutes_q <= snooze_minutes_d;
      ring_sec_q       <= ring_sec_d;
      armed_q          <= armed_d;
      snooze_prev_q    <= snooze_button;
      stop_prev_q      <= stop_button;
    end
  end

  assign alarm_sound    = alarm_sound_q;
  assign snooze_active  = snooze_active_q;
  assign snooze_count   = snooze_count_q;
  assign snooze_hours   = snooze_hours_q;
  assign snooze_minutes = snooze_minutes_q;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Directed bench for alarm_ring_controller: a per-cycle vector table plus
// hand-written multi-cycle sequences for snooze limits, timeout, aborts and reset.
module tb_alarm_ring_controller;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, on_off_alarm, set_alarm_en, snooze_button, stop_button;
  logic [4:0] normal_hours, alarm_hours;
  logic [5:0] normal_minutes, alarm_minutes;
  logic       alarm_sound, snooze_active;
  logic [1:0] snooze_count;
  logic [4:0] snooze_hours;
  logic [5:0] snooze_minutes;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alarm_ring_controller dut (
    .clk            (clk),
    .rst            (rst),
    .tick_1hz       (tick_1hz),
    .normal_hours   (normal_hours),
    .normal_minutes (normal_minutes),
    .alarm_hours    (alarm_hours),
    .alarm_minutes  (alarm_minutes),
    .on_off_alarm   (on_off_alarm),
    .set_alarm_en   (set_alarm_en),
    .snooze_button  (snooze_button),
    .stop_button    (stop_button),
    .alarm_sound    (alarm_sound),
    .snooze_active  (snooze_active),
    .snooze_count   (snooze_count),
    .snooze_hours   (snooze_hours),
    .snooze_minutes (snooze_minutes)
  );

  typedef struct {
    logic       rst, tick;
    logic [4:0] nh;
    logic [5:0] nm;
    logic [4:0] ah;
    logic [5:0] am;
    logic       on, set, snz, stp;
    logic       e_sound, e_sact;
    logic [1:0] e_cnt;
    logic [4:0] e_sh;
    logic [5:0] e_sm;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(int r, int t, int nh, int nm, int ah, int am, int on, int st,
                              int sz, int sp, int es, int ea, int ec, int eh, int em);
    vec_t v;
    v.rst = 1'(r);   v.tick = 1'(t);
    v.nh  = 5'(nh);  v.nm   = 6'(nm);
    v.ah  = 5'(ah);  v.am   = 6'(am);
    v.on  = 1'(on);  v.set  = 1'(st);
    v.snz = 1'(sz);  v.stp  = 1'(sp);
    v.e_sound = 1'(es); v.e_sact = 1'(ea);
    v.e_cnt   = 2'(ec); v.e_sh   = 5'(eh); v.e_sm = 6'(em);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m);
    normal_hours   = 5'(h);
    normal_minutes = 6'(m);
  endtask

  task automatic set_alarm(input int h, input int m);
    alarm_hours   = 5'(h);
    alarm_minutes = 6'(m);
  endtask

  task automatic chk3(input string tag, input int s, input int a, input int c);
    chk({tag, "_sound"}, 32'(alarm_sound), 32'(s));
    chk({tag, "_sact"},  32'(snooze_active), 32'(a));
    chk({tag, "_cnt"},   32'(snooze_count), 32'(c));
  endtask

  task automatic chk_sched(input string tag, input int h, input int m);
    chk({tag, "_sh"}, 32'(snooze_hours), 32'(h));
    chk({tag, "_sm"}, 32'(snooze_minutes), 32'(m));
  endtask

  // Rings the alarm at h:m by stepping time from the minute before.
  task automatic ring_at(input string tag, input int h, input int m, input int ph, input int pm);
    set_alarm(h, m);
    set_time(ph, pm);
    step(); step();
    set_time(h, m);
    step();
    chk3(tag, 1, 0, 0);
  endtask

  initial begin
    rst = 1'b0; tick_1hz = 1'b0; on_off_alarm = 1'b1; set_alarm_en = 1'b0;
    snooze_button = 1'b0; stop_button = 1'b0;
    set_time(0, 0); set_alarm(0, 0);

    //             rst tk  nh  nm  ah  am on st sz sp  snd act cnt sh sm
    vecs[0]  = mk(0, 0,  7, 29,  7, 30, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0,  7, 29,  7, 30, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0,  7, 30,  7, 30, 1, 0, 0, 0,  1, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1,  7, 30,  7, 30, 1, 0, 0, 0,  1, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0,  7, 30,  7, 30, 1, 0, 0, 1,  0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0,  7, 30,  7, 30, 1, 0, 0, 1,  0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 0,  7, 30,  7, 30, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 1,  7, 30,  7, 30, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 23, 57, 23, 58, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 0, 23, 58, 23, 58, 1, 0, 0, 0,  1, 0, 0, 0, 0);
    vecs[10] = mk(1, 0, 23, 58, 23, 58, 1, 0, 1, 0,  0, 1, 1, 0, 3);
    vecs[11] = mk(1, 0, 23, 59, 23, 58, 1, 0, 1, 0,  0, 1, 1, 0, 3);
    vecs[12] = mk(1, 0,  0,  2, 23, 58, 1, 0, 0, 0,  0, 1, 1, 0, 3);
    vecs[13] = mk(1, 0,  0,  3, 23, 58, 1, 0, 0, 0,  1, 0, 1, 0, 3);
    vecs[14] = mk(1, 0,  0,  3, 23, 58, 1, 0, 0, 1,  0, 0, 0, 0, 3);
    vecs[15] = mk(1, 0,  0,  3, 23, 58, 1, 0, 0, 0,  0, 0, 0, 0, 3);

    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst; tick_1hz = vecs[i].tick;
      normal_hours = vecs[i].nh; normal_minutes = vecs[i].nm;
      alarm_hours = vecs[i].ah; alarm_minutes = vecs[i].am;
      on_off_alarm = vecs[i].on; set_alarm_en = vecs[i].set;
      snooze_button = vecs[i].snz; stop_button = vecs[i].stp;
      step();
      chk3($sformatf("v%0d", i), 32'(vecs[i].e_sound), 32'(vecs[i].e_sact), 32'(vecs[i].e_cnt));
      chk_sched($sformatf("v%0d", i), 32'(vecs[i].e_sh), 32'(vecs[i].e_sm));
    end
    tick_1hz = 1'b0; stop_button = 1'b0; snooze_button = 1'b0;

    // Three snoozes from 06:00, held button gives one event, fourth is ignored
    ring_at("s3_ring", 6, 0, 5, 59);
    snooze_button = 1'b1; step();
    chk3("s3_snz1", 0, 1, 1); chk_sched("s3_snz1", 6, 5);
    set_time(6, 5); step();
    chk3("s3_rering1", 1, 0, 1);
    step();
    chk3("s3_held", 1, 0, 1);
    snooze_button = 1'b0; step();
    snooze_button = 1'b1; step();
    chk3("s3_snz2", 0, 1, 2); chk_sched("s3_snz2", 6, 10);
    snooze_button = 1'b0; set_time(6, 10); step();
    chk3("s3_rering2", 1, 0, 2);
    snooze_button = 1'b1; step();
    chk3("s3_snz3", 0, 1, 3); chk_sched("s3_snz3", 6, 15);
    snooze_button = 1'b0; set_time(6, 15); step();
    chk3("s3_rering3", 1, 0, 3);
    snooze_button = 1'b1; step();
    chk3("s3_snz4", 1, 0, 3); chk_sched("s3_snz4", 6, 15);
    snooze_button = 1'b0; step();
    chk3("s3_still", 1, 0, 3);
    stop_button = 1'b1; step();
    chk3("s3_stop", 0, 0, 0);
    stop_button = 1'b0; step();

    // Timeout: 60 ticks after a snooze re-ring
    ring_at("to_ring", 10, 0, 9, 59);
    snooze_button = 1'b1; step();
    chk3("to_snz", 0, 1, 1);
    snooze_button = 1'b0; set_time(10, 5); step();
    chk3("to_rering", 1, 0, 1);
    for (int i = 1; i <= 59; i++) begin
      tick_1hz = 1'b1; step();
      tick_1hz = 1'b0; step();
    end
    chk3("to_tick59", 1, 0, 1);
    tick_1hz = 1'b1; step();
    chk3("to_tick60", 0, 0, 0);
    tick_1hz = 1'b0; step();

    // Stop and snooze on the same cycle: stop wins
    ring_at("ss_ring", 12, 0, 11, 59);
    stop_button = 1'b1; snooze_button = 1'b1; step();
    chk3("ss_both", 0, 0, 0);
    stop_button = 1'b0; snooze_button = 1'b0; step();

    // Disable while snoozed: no re-ring at the snooze time
    ring_at("off_ring", 12, 2, 12, 1);
    snooze_button = 1'b1; step();
    chk3("off_snz", 0, 1, 1); chk_sched("off_snz", 12, 7);
    snooze_button = 1'b0; on_off_alarm = 1'b0; step();
    chk3("off_drop", 0, 0, 0);
    set_time(12, 7); step(); step();
    chk3("off_at_sched", 0, 0, 0);
    on_off_alarm = 1'b1; step(); step();
    chk3("off_reenable", 0, 0, 0);

    // Entering alarm edit mode aborts ringing
    ring_at("ed_ring", 15, 0, 14, 59);
    set_alarm_en = 1'b1; step();
    chk3("ed_abort", 0, 0, 0);
    set_alarm_en = 1'b0; step();
    chk3("ed_norering", 0, 0, 0);

    // Reset mid-ring, then released inside the matching minute
    ring_at("rs_ring", 13, 0, 12, 59);
    snooze_button = 1'b1; step();
    chk3("rs_snz", 0, 1, 1); chk_sched("rs_snz", 13, 5);
    snooze_button = 1'b0; set_time(13, 5); step();
    chk3("rs_rering", 1, 0, 1);
    set_alarm(13, 5);
    rst = 1'b0; step();
    chk3("rs_reset", 0, 0, 0); chk_sched("rs_reset", 0, 0);
    rst = 1'b1; step(); step(); step();
    chk3("rs_same_min", 0, 0, 0);
    set_time(13, 6); step();
    chk3("rs_next_min", 0, 0, 0);
    set_time(13, 5); step();
    chk3("rs_recur", 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
